output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 5: requester count (N, E, S, W, Local buffer units); index 0..4.
REQ-002 Parameter SEL_W, default 3: width of sel, ceil(log2(N_REQ)).
REQ-003 Parameter TIMEOUT_CYCLES, default 1023: grant-hold limit; used only when ARB_TIMEOUT_EN is defined.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port req_port, input, N_REQ: per-buffer-unit port request; held for the full packet transfer.
REQ-007 Port grant_port, output, N_REQ: one-hot or zero grant to buffer units.
REQ-008 Port sel, output, SEL_W: index of the granted requester, driven to the crossbar mux; 0 when no grant.
REQ-009 Port busy, output, 1: high whenever grant_port is nonzero.
REQ-010 Port timeout_err, output, 1: one-cycle pulse on forced release.

Function
REQ-011 FSM states: IDLE, GRANT, FLUSH; all outputs registered.
REQ-012 IDLE, req_port nonzero: select a winner round-robin, searching from index ptr+1 upward with wrap, where ptr is the last granted index.
REQ-013 On selection, the next edge sets grant_port to the winner's one-hot, sets sel to the winner, and moves to GRANT; request-to-grant latency is 1 cycle.
REQ-014 IDLE, req_port zero: grant_port stays 0 and state stays IDLE.
REQ-015 GRANT: grant is locked; changes on other req_port bits are ignored.
REQ-016 GRANT, req_port[g] drops: the next edge clears grant_port and sel, sets ptr to g, and moves to IDLE.
REQ-017 Between successive grants there is at least one cycle with grant_port = 0.
REQ-018 Simultaneous requests are resolved only by the round-robin order.
REQ-019 A requester that dropped its request is eligible again only after every other active requester has been served once.
REQ-020 A single persistent requester is re-granted after each 1-cycle gap.
REQ-021 grant_port never has more than one bit set.
REQ-022 grant_port is never asserted to a requester whose req_port bit was low on the deciding edge.
REQ-023 FLUSH is reachable only with ARB_TIMEOUT_EN.
REQ-024 FLUSH: grant_port is 0; the arbiter waits for req_port[g] low, then moves to IDLE with ptr set to g.

Reset
REQ-025 rst low asynchronously forces state IDLE, grant_port 0, sel 0, busy 0, timeout_err 0, hold counter 0.
REQ-026 rst low forces ptr to N_REQ-1, so index 0 has first priority after reset.
REQ-027 Reset asserted mid-grant drops the grant immediately, with no completion of the transfer.
REQ-028 After reset release, arbitration resumes on the first clk edge that sees rst high.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: a hold counter is cleared on entering GRANT and increments each GRANT cycle.
REQ-030 With ARB_TIMEOUT_EN, the edge on which the counter equals TIMEOUT_CYCLES-1 and the request is still high clears grant_port, pulses timeout_err for 1 cycle, and moves to FLUSH.
REQ-031 If the request drop and the timeout occur on the same edge, the drop wins: no timeout_err, and the next state is IDLE.
REQ-032 Macro ARB_TIMEOUT_EN undefined: no counter and no FLUSH state exist; timeout_err is tied 0; a grant is held indefinitely.

Verification
REQ-033 Reset release, then req_port=00001 on cycle 2 -> grant_port=00001, sel=0 on cycle 3; busy=1.
REQ-034 req_port=11111 held, each requester dropping after 4 granted cycles -> grant order 0,1,2,3,4,0 with exactly a 1-cycle zero gap between grants.
REQ-035 Grant to 2 active, req_port[3] rises -> grant_port remains 00100 until req_port[2] falls; grant 01000 follows after the gap.
REQ-036 Reset pulsed low mid-grant to 1 -> grant_port=0 the same cycle, and the next grant goes to index 0 if req_port[0] is high.
REQ-037 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, req_port[4] held high -> grant drops after 8 grant cycles, timeout_err pulses once, and there is no new grant until req_port[4] falls.
REQ-038 ARB_TIMEOUT_EN, req_port[1] falls on the timeout edge -> timeout_err stays 0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin output-port arbiter for a 5-port router: one registered grant held for a whole packet.
// Optional grant-hold timeout with forced release and flush is enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module output_port_arbiter #(
    parameter int N_REQ          = 5,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_port,
    output logic [N_REQ-1:0] grant_port,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
`ifdef ARB_TIMEOUT_EN
    localparam logic [1:0] FLUSH = 2'd2;
    localparam int         CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]      hold_cnt;
`endif

    logic [1:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cur;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;
    logic [N_REQ-1:0] winner_onehot;
    logic             found;

    // Search starts one past the last granted index, so the previous owner goes last.
    // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
    always_comb begin
        found         = 1'b0;
        winner        = '0;
        idx           = '0;
        winner_onehot = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i >= N_REQ) ? SEL_W'(int'(ptr) + i - N_REQ)
                                           : SEL_W'(int'(ptr) + i);
            if (!found && req_port[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        winner_onehot[winner] = found;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_port  <= '0;
            sel         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            cur         <= '0;
            ptr         <= SEL_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_port <= winner_onehot;
                        sel        <= winner;
                        cur        <= winner;
                        busy       <= 1'b1;
                        state      <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A request drop takes precedence over a coincident timeout.
                    if (!req_port[cur]) begin
                        grant_port <= '0;
                        sel        <= '0;
                        busy       <= 1'b0;
                        ptr        <= cur;
                        state      <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        grant_port  <= '0;
                        sel         <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= FLUSH;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                FLUSH: begin
                    // Wait for the stalled owner to withdraw before arbitrating again.
                    if (!req_port[cur]) begin
                        ptr   <= cur;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    grant_port <= '0;
                    sel        <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: vector table plus hand-written multi-cycle sequences.
// Timeout sequences run only when ARB_TIMEOUT_EN is defined; otherwise indefinite hold is checked.
`timescale 1ns/1ps

module tb_output_port_arbiter;

    localparam int N_REQ = 5;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] req_port;
    logic [N_REQ-1:0] grant_port;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N_REQ-1:0] grant;
        logic [SEL_W-1:0] sel;
        logic             busy;
        logic             terr;
    } exp_t;

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] grant;
        logic [SEL_W-1:0] sel;
        string            name;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[19];

    output_port_arbiter #(
        .N_REQ(N_REQ),
        .SEL_W(SEL_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_port(req_port),
        .grant_port(grant_port),
        .sel(sel),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive req at a falling edge, queue what the next rising edge must produce, compare one cycle later.
    task automatic step(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] g,
                        input logic [SEL_W-1:0] s, input logic t, input string name);
        exp_t e;
        exp_t got;
        e.grant  = g;
        e.sel    = s;
        e.busy   = (g != '0);
        e.terr   = t;
        req_port = req;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb_q.pop_front();
            check({name, ".grant"}, 32'(grant_port), 32'(got.grant));
            check({name, ".sel"},   32'(sel),        32'(got.sel));
            check({name, ".busy"},  32'(busy),       32'(got.busy));
            check({name, ".terr"},  32'(timeout_err), 32'(got.terr));
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst      = 1'b0;
        req_port = '0;
        repeat (2) @(negedge clk);
        check({name, ".rst_grant"}, 32'(grant_port), 32'd0);
        check({name, ".rst_sel"},   32'(sel),        32'd0);
        check({name, ".rst_busy"},  32'(busy),       32'd0);
        check({name, ".rst_terr"},  32'(timeout_err), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_REQ-1:0] g;
        int               order[6];

        rst      = 1'b0;
        req_port = '0;

        vecs[0]  = '{5'b00000, 5'b00000, 3'd0, "idle"};
        vecs[1]  = '{5'b00001, 5'b00001, 3'd0, "first_grant0"};
        vecs[2]  = '{5'b00001, 5'b00001, 3'd0, "hold0"};
        vecs[3]  = '{5'b11111, 5'b00001, 3'd0, "locked0"};
        vecs[4]  = '{5'b11110, 5'b00000, 3'd0, "release0"};
        vecs[5]  = '{5'b11110, 5'b00010, 3'd1, "rr_grant1"};
        vecs[6]  = '{5'b11110, 5'b00010, 3'd1, "hold1"};
        vecs[7]  = '{5'b11100, 5'b00000, 3'd0, "release1"};
        vecs[8]  = '{5'b11101, 5'b00100, 3'd2, "skip0_grant2"};
        vecs[9]  = '{5'b01101, 5'b00100, 3'd2, "others_change"};
        vecs[10] = '{5'b01001, 5'b00000, 3'd0, "release2"};
        vecs[11] = '{5'b01001, 5'b01000, 3'd3, "grant3"};
        vecs[12] = '{5'b00001, 5'b00000, 3'd0, "release3"};
        vecs[13] = '{5'b00001, 5'b00001, 3'd0, "wrap_grant0"};
        vecs[14] = '{5'b00000, 5'b00000, 3'd0, "release0b"};
        vecs[15] = '{5'b00000, 5'b00000, 3'd0, "idle_b"};
        vecs[16] = '{5'b10000, 5'b10000, 3'd4, "grant4"};
        vecs[17] = '{5'b00000, 5'b00000, 3'd0, "release4"};
        vecs[18] = '{5'b00000, 5'b00000, 3'd0, "idle_c"};

        do_reset("tbl");
        foreach (vecs[i]) step(vecs[i].req, vecs[i].grant, vecs[i].sel, 1'b0, vecs[i].name);

        // All five requesting; each holds 4 granted cycles then drops for one cycle.
        order = '{0, 1, 2, 3, 4, 0};
        do_reset("rr");
        for (int k = 0; k < 6; k++) begin
            g = '0;
            g[order[k]] = 1'b1;
            for (int c = 0; c < 4; c++) step(5'b11111, g, SEL_W'(order[k]), 1'b0, $sformatf("rr%0d_c%0d", k, c));
            step(5'b11111 & ~g, 5'b00000, 3'd0, 1'b0, $sformatf("rr%0d_gap", k));
        end

        // Asynchronous reset in the middle of a grant to requester 1.
        do_reset("mid");
        step(5'b00010, 5'b00010, 3'd1, 1'b0, "mid_grant1");
        step(5'b00011, 5'b00010, 3'd1, 1'b0, "mid_hold1");
        #2 rst = 1'b0;
        #1;
        check("mid_async_grant", 32'(grant_port), 32'd0);
        check("mid_async_sel",   32'(sel),        32'd0);
        check("mid_async_busy",  32'(busy),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(5'b00011, 5'b00001, 3'd0, 1'b0, "post_reset_idx0");

`ifdef ARB_TIMEOUT_EN
        do_reset("to");
        for (int c = 0; c < 8; c++) step(5'b10000, 5'b10000, 3'd4, 1'b0, $sformatf("to_hold%0d", c));
        step(5'b10000, 5'b00000, 3'd0, 1'b1, "to_fire");
        for (int c = 0; c < 3; c++) step(5'b10000, 5'b00000, 3'd0, 1'b0, $sformatf("to_flush%0d", c));
        step(5'b00000, 5'b00000, 3'd0, 1'b0, "to_flush_exit");
        step(5'b10000, 5'b10000, 3'd4, 1'b0, "to_regrant4");

        do_reset("drop");
        for (int c = 0; c < 8; c++) step(5'b00010, 5'b00010, 3'd1, 1'b0, $sformatf("drop_hold%0d", c));
        step(5'b00000, 5'b00000, 3'd0, 1'b0, "drop_on_timeout_edge");
        step(5'b00010, 5'b00010, 3'd1, 1'b0, "drop_back_idle");
`else
        do_reset("hold");
        for (int c = 0; c < 20; c++) step(5'b10000, 5'b10000, 3'd4, 1'b0, $sformatf("hold%0d", c));
        step(5'b00000, 5'b00000, 3'd0, 1'b0, "hold_release");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
